// File: rtl/r32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : r32_pkg
//  Description : Shared types and constants for the r32 instruction front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package r32_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam int    INSTR_BYTES           = 4;
    localparam addr_t RESET_VECTOR          = 32'h0000_0200;
    localparam int    FETCH_DEPTH           = 4;
    localparam int    FETCH_MAX_OUTSTANDING = 2;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        addr_t pc;
        word_t data;
    } fetch_entry_t;

    // Clears the byte-offset bits of an address.
    function automatic addr_t word_align(input addr_t a);
        return a & ~addr_t'(INSTR_BYTES - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory channel, decode handshake and redirect
//                port of the fetch unit. "master" is the fetch unit side,
//                "slave" is the memory/decode/branch environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import r32_pkg::*;
#(
    parameter int ADDR_WIDTH = $bits(addr_t),
    parameter int DATA_WIDTH = $bits(word_t)
);
    // Memory request channel
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    // Memory response channel (in order, never back-pressured)
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    // Decode handshake
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;
    // Control-flow redirect
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Registered synchronous FIFO with flush. Output is the stored
//                head (no write-through bypass). Depth need not be a power of
//                two, so pointers wrap explicitly at DEPTH-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import r32_pkg::*;
#(
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int DEPTH = 4
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    input  wire logic                       flush,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           push_data,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           pop_data,
    output logic      [$clog2(DEPTH+1)-1:0] count,
    output logic                            full,
    output logic                            empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = storage[rd_ptr];

    // A pop frees a slot in the same cycle, so push-while-full is allowed alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Sequential instruction-fetch front end. Issues word-aligned
//                fetches from a reset vector with bounded outstanding requests,
//                buffers returned words with their PCs in a prefetch FIFO and
//                flushes/restarts on a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import r32_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = $bits(addr_t),
    parameter int                    DATA_WIDTH      = $bits(word_t),
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(RESET_VECTOR),
    parameter int                    DEPTH           = FETCH_DEPTH,
    parameter int                    MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
    input  wire logic   clock,
    input  wire logic   reset,
    fetch_unit_if.master bus
);
    localparam int                    CNT_W   = $clog2(DEPTH + 1);
    localparam int                    SUM_W   = CNT_W + 1;
    localparam int                    QCNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int                    ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    // Registered state
    logic [ADDR_WIDTH-1:0] pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      drop;

    // Derived control
    logic [CNT_W-1:0]      outstanding_next;
    logic [CNT_W-1:0]      fifo_count;
    logic [SUM_W-1:0]      credit_used;
    logic                  req_valid;
    logic                  req_fire;
    logic                  rsp_discard;
    logic                  rsp_push;
    logic                  instr_pop;
    logic                  instr_valid;

    // FIFO-side signals
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [ENTRY_W-1:0]    head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [QCNT_W-1:0]     pcq_count;
    logic                  pcq_full;
    logic                  pcq_empty;
    logic                  unused_status;

    // Stale in-flight requests still hold credit, so every response that
    // arrives is guaranteed a FIFO slot even if it is later discarded.
    assign credit_used = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign req_valid   = !reset
                         && (outstanding < CNT_W'(MAX_OUTSTANDING))
                         && (credit_used < SUM_W'(DEPTH));
    assign req_fire    = req_valid && bus.mem_req_ready;

    assign rsp_discard = bus.mem_rsp_valid && ((drop != '0) || bus.redirect_valid);
    assign rsp_push    = bus.mem_rsp_valid && !rsp_discard;

    assign instr_valid = !reset && !fifo_empty;
    assign instr_pop   = instr_valid && bus.instr_ready && !bus.redirect_valid;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = pc;
    assign bus.instr_valid   = instr_valid;
    assign bus.instr_pc      = head[ENTRY_W-1:DATA_WIDTH];
    assign bus.instr_data    = head[DATA_WIDTH-1:0];

    assign unused_status = ^{pcq_count, pcq_full, pcq_empty, fifo_full};

    // In-flight count after this cycle's request fire and response return.
    always_comb begin
        outstanding_next = outstanding;
        case ({req_fire, bus.mem_rsp_valid})
            2'b10:   outstanding_next = outstanding + CNT_W'(1);
            2'b01:   outstanding_next = outstanding - CNT_W'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    // Fetch PC, outstanding count and stale-response drop count; redirect wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                pc   <= bus.redirect_pc & ~ADDR_WIDTH'(3);
                drop <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc <= pc + PC_STEP;
                end
                if (bus.mem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
            end
        end
    end

    // Addresses of accepted requests, retired one per response in order.
    // Never flushed: stale entries pop alongside their discarded responses.
    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_req_pc_q (
        .clock     (clock),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc),
        .pop       (bus.mem_rsp_valid),
        .pop_data  (rsp_pc),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    // Prefetch buffer of {pc, instruction} presented to decode.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_prefetch (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (rsp_push),
        .push_data ({rsp_pc, bus.mem_rsp_data}),
        .pop       (instr_pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the r32 core.
- Generates sequential fetch addresses from a reset vector and keeps up to MAX_OUTSTANDING requests in flight on the instruction memory channel.
- Buffers returned words with their PCs in a DEPTH-entry prefetch FIFO and presents them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, fetch address width in bits.
- DATA_WIDTH, 32, instruction word width; the PC increment is DATA_WIDTH/8.
- RESET_PC, 32'h0000_0200, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (1..DEPTH).

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request; fire = valid & ready.
- mem_req_addr  out  ADDR_WIDTH  fetch address, word aligned.
- mem_rsp_valid  in  1  read data valid; in-order, no backpressure.
- mem_rsp_data  in  DATA_WIDTH  read data.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr_data  out  DATA_WIDTH  head instruction.
- instr_pc  out  ADDR_WIDTH  address of head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_WIDTH  new fetch address; bits [1:0] ignored (forced 0).

Behaviour:
- Reset, synchronous and active-high:
  - pc=RESET_PC; outstanding=0; drop=0; FIFO empty.
  - mem_req_valid=0 and instr_valid=0 throughout any cycle with reset high.
  - The first request, addr RESET_PC, is presented the cycle after reset falls.
  - Reset mid-operation abandons all state. The memory side must be reset together with this block; late responses are not tracked.
- Issue rule, all combinational from registered state:
  - mem_req_valid = !reset & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count < DEPTH).
  - Credit counts stale requests conservatively, so a response always has a free FIFO slot.
  - mem_req_addr = pc.
  - On fire: pc += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
  - Address is held while valid & !ready unless a redirect occurs.
- Outstanding counter: +1 on request fire, -1 on mem_rsp_valid. Both in the same cycle leaves it unchanged.
- Response handling:
  - If drop>0 or redirect_valid is high this cycle, the response is discarded; drop decrements when it was >0.
  - Otherwise {pc_of_request, data} is pushed to the FIFO.
  - The request-PC queue is a small internal FIFO of depth MAX_OUTSTANDING, or equivalently a response-PC counter.
  - Push-to-instr_valid latency: 1 cycle (registered FIFO, no bypass). Memory fire to earliest instr_valid is memory latency + 1.
- FIFO:
  - Pop on instr_valid & instr_ready.
  - Simultaneous push and pop while full or empty is legal; count is unchanged when both occur.
  - instr_data and instr_pc are stable while instr_valid & !instr_ready.
- Redirect, taking priority over all same-cycle events:
  - FIFO is flushed; instr_valid=0 next cycle. A same-cycle pop is ignored.
  - pc <= redirect_pc & ~3. Any request firing in that cycle is stale.
  - drop <= outstanding_next, i.e. the count after this cycle's fire/response updates.
  - Next request is redirect_pc, issued the following cycle if credit allows.
  - Back-to-back redirects: the last one wins; drop is recomputed each time.
- Wrap-around: pc 32'hFFFF_FFFC fires, then the next address is 32'h0000_0000. No fault is raised.
- No error or misalignment signalling in this block.

Decomposition:
- Shared package r32_pkg: addr_t, word_t, INSTR_BYTES=4, RESET_VECTOR=32'h200.
- Sub-module fetch_fifo: synchronous FIFO of {addr_t, word_t} with push, pop, flush, count, full and empty. It is reused for the request-PC queue with DEPTH=MAX_OUTSTANDING.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle response latency, instr_ready=1 -> requests at 0x200, 0x204, 0x208...; instr_pc follows the same sequence with correct data; never more than 2 outstanding.
- instr_ready=0 with DEPTH=4 -> exactly 4 words buffered (0x200..0x20C), mem_req_valid stays low, no response lost; raising instr_ready drains them in order.
- Redirect to 0x1000 with 2 requests outstanding and 1 FIFO entry -> FIFO empties; next 2 responses dropped; next delivered instr_pc=0x1000.
- Redirect in the same cycle as a request fire and a response -> that response is dropped, drop=outstanding_next, and the first delivered instruction is from redirect_pc.
- mem_req_ready toggled randomly for 500 cycles -> mem_req_addr stable while stalled; delivered PCs strictly sequential.
- Reset asserted mid-stream with a full FIFO -> next cycle instr_valid=0, mem_req_valid=0; after release the fetch restarts at 0x200.
